sort_sequencer: RTL and testbench

- Controller that sequences the weigh-station datapath: qualifies a stable scale reading, classifies it into weight groups 1-6, and emits one count strobe per package.
- Drives the six diverter gates for a fixed window, then waits for the scale to clear before accepting the next package.
- Sits between the scale's 12-bit weight bus and the group counters / diverter actuators.
- Replaces level-sensitive counting with an explicit FSM that has debounce and timeout.

---
 rtl/sort_pkg.sv | 43 ++++
 rtl/sort_classifier.sv | 51 +++++
 rtl/sort_sequencer.sv | 159 +++++++++++++++
 tb/tb_sort_sequencer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/sort_pkg.sv
// Shared types, widths and weight-group thresholds for the weigh-station sort sequencer.
package sort_pkg;

    localparam int GRP_W    = 3;
    localparam int WEIGHT_W = 12;
    localparam int GATE_W   = 7;

    localparam logic [WEIGHT_W-1:0] THR_G1 = 12'd250;
    localparam logic [WEIGHT_W-1:0] THR_G2 = 12'd500;
    localparam logic [WEIGHT_W-1:0] THR_G3 = 12'd750;
    localparam logic [WEIGHT_W-1:0] THR_G4 = 12'd1500;
    localparam logic [WEIGHT_W-1:0] THR_G5 = 12'd2000;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        SETTLE     = 3'd1,
        DIVERT     = 3'd2,
        WAIT_CLEAR = 3'd3,
        FAULT      = 3'd4
    } state_t;

    // Thresholds are inclusive upper limits; an empty scale maps to no group.
    function automatic logic [GRP_W-1:0] weight_to_grp(input logic [WEIGHT_W-1:0] weight);
        logic [GRP_W-1:0] grp;
        if (weight == 12'd0) begin
            grp = 3'd0;
        end else if (weight <= THR_G1) begin
            grp = 3'd1;
        end else if (weight <= THR_G2) begin
            grp = 3'd2;
        end else if (weight <= THR_G3) begin
            grp = 3'd3;
        end else if (weight <= THR_G4) begin
            grp = 3'd4;
        end else if (weight <= THR_G5) begin
            grp = 3'd5;
        end else begin
            grp = 3'd6;
        end
        return grp;
    endfunction

endpackage

// File: rtl/sort_classifier.sv
// Combinational weight -> group / one-hot gate mapping.
// Optional reject group 7 above MAX_WEIGHT when SORT_SEQ_REJECT_EN is defined.
module sort_classifier
    import sort_pkg::*;
#(
    parameter int MAX_WEIGHT = 3000
) (
    input  logic [WEIGHT_W-1:0] w_q,
    output logic [GRP_W-1:0]    grp,
    output logic [GATE_W-1:0]   onehot
);

    logic [GRP_W-1:0]  grp_s;
    logic [GATE_W-1:0] onehot_s;

`ifndef SORT_SEQ_REJECT_EN
    logic [31:0] unused_max_weight_s;
    assign unused_max_weight_s = 32'(MAX_WEIGHT);
`endif

    // Map the held weight to its group and the matching diverter bit
    always_comb begin
        grp_s    = 3'd0;
        onehot_s = 7'b000_0000;
`ifdef SORT_SEQ_REJECT_EN
        if (w_q > WEIGHT_W'(MAX_WEIGHT)) begin
            grp_s = 3'd7;
        end else begin
            grp_s = weight_to_grp(w_q);
        end
`else
        grp_s = weight_to_grp(w_q);
`endif
        case (grp_s)
            3'd1:    onehot_s = 7'b000_0001;
            3'd2:    onehot_s = 7'b000_0010;
            3'd3:    onehot_s = 7'b000_0100;
            3'd4:    onehot_s = 7'b000_1000;
            3'd5:    onehot_s = 7'b001_0000;
            3'd6:    onehot_s = 7'b010_0000;
`ifdef SORT_SEQ_REJECT_EN
            3'd7:    onehot_s = 7'b100_0000;
`endif
            default: onehot_s = 7'b000_0000;
        endcase
    end

    assign grp    = grp_s;
    assign onehot = onehot_s;

endmodule

// File: rtl/sort_sequencer.sv
// Weigh-station sequencer: debounce scale reading, classify, strobe one count, divert, await clear.
// Define SORT_SEQ_REJECT_EN to route overweight packages (> MAX_WEIGHT) to reject group 7.
module sort_sequencer
    import sort_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int DIVERT_CYCLES = 8,
    parameter int CLEAR_TIMEOUT = 255,
    parameter int MAX_WEIGHT    = 3000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [WEIGHT_W-1:0] weight,
    input  logic                fault_clr,
    output logic                count_en,
    output logic [GRP_W-1:0]    count_grp,
    output logic [GATE_W-1:0]   gate_sel,
    output logic                busy,
    output logic                fault,
    output logic [2:0]          state
);

    localparam int STAB_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int DIV_W  = (DIVERT_CYCLES > 1) ? $clog2(DIVERT_CYCLES) : 1;
    localparam int TMO_W  = (CLEAR_TIMEOUT > 1) ? $clog2(CLEAR_TIMEOUT) : 1;
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(SETTLE_CYCLES - 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIVERT_CYCLES - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(CLEAR_TIMEOUT - 1);

    state_t              state_r, state_nxt_s;
    logic [WEIGHT_W-1:0] w_q_r, w_q_nxt_s;
    logic [STAB_W-1:0]   stab_r, stab_nxt_s;
    logic [DIV_W-1:0]    div_r, div_nxt_s;
    logic [TMO_W-1:0]    tmo_r, tmo_nxt_s;
    logic [GRP_W-1:0]    cls_grp_s;
    logic [GATE_W-1:0]   cls_onehot_s;

    logic                count_en_r, count_en_nxt_s;
    logic [GRP_W-1:0]    count_grp_r, count_grp_nxt_s;
    logic [GATE_W-1:0]   gate_sel_r, gate_sel_nxt_s;
    logic                busy_r, fault_r;

    sort_classifier #(
        .MAX_WEIGHT (MAX_WEIGHT)
    ) u_classifier (
        .w_q    (w_q_r),
        .grp    (cls_grp_s),
        .onehot (cls_onehot_s)
    );

    // Next-state and counter update; w_q is frozen outside SETTLE/IDLE, which holds the group
    always_comb begin
        state_nxt_s = state_r;
        w_q_nxt_s   = w_q_r;
        stab_nxt_s  = stab_r;
        div_nxt_s   = div_r;
        tmo_nxt_s   = tmo_r;
        case (state_r)
            IDLE: begin
                if (weight != 12'd0) begin
                    state_nxt_s = SETTLE;
                    w_q_nxt_s   = weight;
                    stab_nxt_s  = STAB_W'(0);
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SETTLE: begin
                if (weight == 12'd0) begin
                    state_nxt_s = IDLE;
                end else if (weight != w_q_r) begin
                    w_q_nxt_s  = weight;
                    stab_nxt_s = STAB_W'(0);
                end else if (stab_r == STAB_LAST) begin
                    state_nxt_s = DIVERT;
                    div_nxt_s   = DIV_W'(0);
                end else begin
                    stab_nxt_s = stab_r + STAB_W'(1);
                end
            end
            DIVERT: begin
                if (div_r == DIV_LAST) begin
                    state_nxt_s = WAIT_CLEAR;
                    tmo_nxt_s   = TMO_W'(0);
                end else begin
                    div_nxt_s = div_r + DIV_W'(1);
                end
            end
            WAIT_CLEAR: begin
                if (weight == 12'd0) begin
                    state_nxt_s = IDLE;
                end else if (tmo_r == TMO_LAST) begin
                    state_nxt_s = FAULT;
                end else begin
                    tmo_nxt_s = tmo_r + TMO_W'(1);
                end
            end
            FAULT: begin
                if (fault_clr && (weight == 12'd0)) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = FAULT;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Outputs are computed for the upcoming state so they register in step with it
    always_comb begin
        count_en_nxt_s  = 1'b0;
        count_grp_nxt_s = 3'd0;
        gate_sel_nxt_s  = 7'b000_0000;
        if (state_nxt_s == DIVERT) begin
            count_en_nxt_s  = (state_r != DIVERT);
            count_grp_nxt_s = cls_grp_s;
            gate_sel_nxt_s  = cls_onehot_s;
        end else begin
            count_en_nxt_s  = 1'b0;
            count_grp_nxt_s = 3'd0;
            gate_sel_nxt_s  = 7'b000_0000;
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            w_q_r       <= 12'd0;
            stab_r      <= STAB_W'(0);
            div_r       <= DIV_W'(0);
            tmo_r       <= TMO_W'(0);
            count_en_r  <= 1'b0;
            count_grp_r <= 3'd0;
            gate_sel_r  <= 7'b000_0000;
            busy_r      <= 1'b0;
            fault_r     <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            w_q_r       <= w_q_nxt_s;
            stab_r      <= stab_nxt_s;
            div_r       <= div_nxt_s;
            tmo_r       <= tmo_nxt_s;
            count_en_r  <= count_en_nxt_s;
            count_grp_r <= count_grp_nxt_s;
            gate_sel_r  <= gate_sel_nxt_s;
            busy_r      <= (state_nxt_s != IDLE);
            fault_r     <= (state_nxt_s == FAULT);
        end
    end

    assign count_en  = count_en_r;
    assign count_grp = count_grp_r;
    assign gate_sel  = gate_sel_r;
    assign busy      = busy_r;
    assign fault     = fault_r;
    assign state     = state_r;

endmodule

// File: tb/tb_sort_sequencer.sv
// Directed self-checking bench for sort_sequencer (default parameters).
// Honours SORT_SEQ_REJECT_EN for the overweight expectation.
module tb_sort_sequencer;

    logic        clk;
    logic        reset;
    logic [11:0] weight;
    logic        fault_clr;
    logic        count_en;
    logic [2:0]  count_grp;
    logic [6:0]  gate_sel;
    logic        busy;
    logic        fault;
    logic [2:0]  state;

    int tests = 0;
    int fails = 0;

    localparam logic [2:0] S_IDLE = 3'd0, S_SETTLE = 3'd1, S_DIVERT = 3'd2,
                           S_WAIT = 3'd3, S_FAULT = 3'd4;

    sort_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .weight    (weight),
        .fault_clr (fault_clr),
        .count_en  (count_en),
        .count_grp (count_grp),
        .gate_sel  (gate_sel),
        .busy      (busy),
        .fault     (fault),
        .state     (state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    // Load a package from IDLE and follow it through DIVERT into WAIT_CLEAR
    task automatic run_to_wait(input string tag, input logic [11:0] w, input logic [2:0] g);
        logic [6:0] exp_gate;
        int en_cnt;
        int bad;
        exp_gate = 7'd1 << (g - 3'd1);
        weight = w;
        repeat (4) tick;
        chk({tag, "_settle_state"}, state, S_SETTLE);
        chk({tag, "_settle_en"}, count_en, 1'b0);
        tick;
        chk({tag, "_div_state"}, state, S_DIVERT);
        chk({tag, "_div_en"}, count_en, 1'b1);
        chk({tag, "_div_grp"}, count_grp, g);
        chk({tag, "_div_gate"}, gate_sel, exp_gate);
        en_cnt = 1;
        bad = 0;
        for (int i = 1; i < 8; i++) begin
            tick;
            en_cnt += int'(count_en);
            if (gate_sel !== exp_gate || count_grp !== g || state !== S_DIVERT) bad++;
        end
        chk({tag, "_div_hold"}, bad, 0);
        tick;
        chk({tag, "_wait_state"}, state, S_WAIT);
        chk({tag, "_wait_gate"}, gate_sel, 7'd0);
        chk({tag, "_wait_grp"}, count_grp, 3'd0);
        chk({tag, "_en_count"}, en_cnt, 1);
    endtask

    task automatic run_pkg(input string tag, input logic [11:0] w, input logic [2:0] g);
        run_to_wait(tag, w, g);
        weight = 12'd0;
        tick;
        chk({tag, "_idle_state"}, state, S_IDLE);
        chk({tag, "_idle_busy"}, busy, 1'b0);
    endtask

    initial begin
        int viol;
        reset = 1'b1;
        weight = 12'd0;
        fault_clr = 1'b0;
        tick;
        tick;
        chk("rst_state", state, S_IDLE);
        chk("rst_en", count_en, 1'b0);
        chk("rst_grp", count_grp, 3'd0);
        chk("rst_gate", gate_sel, 7'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_fault", fault, 1'b0);
        reset = 1'b0;
        tick;
        chk("idle_hold", state, S_IDLE);

        // Stable-weight path
        weight = 12'd300;
        tick;
        chk("w300_enter_settle", state, S_SETTLE);
        chk("w300_busy", busy, 1'b1);
        weight = 12'd0;
        tick;
        chk("w300_glitch_idle", state, S_IDLE);
        run_pkg("w300", 12'd300, 3'd2);

        // Boundary classification
        run_pkg("b250", 12'd250, 3'd1);
        run_pkg("b251", 12'd251, 3'd2);
        run_pkg("b500", 12'd500, 3'd2);
        run_pkg("b750", 12'd750, 3'd3);
        run_pkg("b751", 12'd751, 3'd4);
        run_pkg("b1500", 12'd1500, 3'd4);
        run_pkg("b2000", 12'd2000, 3'd5);
        run_pkg("b2001", 12'd2001, 3'd6);
`ifdef SORT_SEQ_REJECT_EN
        run_pkg("b3500", 12'd3500, 3'd7);
`else
        run_pkg("b3500", 12'd3500, 3'd6);
`endif

        // Bounce and weight change during settling
        weight = 12'd400;
        tick;
        chk("bnc_settle1", state, S_SETTLE);
        weight = 12'd0;
        tick;
        chk("bnc_idle", state, S_IDLE);
        chk("bnc_idle_en", count_en, 1'b0);
        weight = 12'd400;
        tick;
        tick;
        tick;
        weight = 12'd410;
        tick;
        tick;
        tick;
        tick;
        chk("bnc_still_settle", state, S_SETTLE);
        chk("bnc_no_en", count_en, 1'b0);
        tick;
        chk("bnc_div_en", count_en, 1'b1);
        chk("bnc_div_grp", count_grp, 3'd2);
        viol = 0;
        for (int i = 0; i < 8; i++) begin
            tick;
            viol += int'(count_en);
        end
        chk("bnc_single_en", viol, 0);
        chk("bnc_wait", state, S_WAIT);
        weight = 12'd0;
        tick;
        chk("bnc_idle_end", state, S_IDLE);

        // Scale never clears -> timeout fault
        run_to_wait("tmo", 12'd1000, 3'd4);
        viol = 0;
        for (int i = 0; i < 254; i++) begin
            tick;
            if (count_en !== 1'b0 || gate_sel !== 7'd0 || state !== S_WAIT) viol++;
        end
        chk("tmo_wait_quiet", viol, 0);
        chk("tmo_no_fault_yet", fault, 1'b0);
        tick;
        chk("tmo_fault_state", state, S_FAULT);
        chk("tmo_fault", fault, 1'b1);
        fault_clr = 1'b1;
        tick;
        chk("tmo_clr_loaded", fault, 1'b1);
        fault_clr = 1'b0;
        weight = 12'd0;
        tick;
        chk("tmo_empty_noclr", fault, 1'b1);
        fault_clr = 1'b1;
        tick;
        chk("tmo_clr_state", state, S_IDLE);
        chk("tmo_clr_fault", fault, 1'b0);
        fault_clr = 1'b0;

        // Asynchronous reset in the third DIVERT cycle
        weight = 12'd600;
        repeat (4) tick;
        tick;
        chk("rmid_div_en", count_en, 1'b1);
        chk("rmid_div_grp", count_grp, 3'd3);
        tick;
        tick;
        chk("rmid_div3_gate", gate_sel, 7'b000_0100);
        reset = 1'b1;
        #1;
        chk("rmid_gate", gate_sel, 7'd0);
        chk("rmid_busy", busy, 1'b0);
        chk("rmid_state", state, S_IDLE);
        chk("rmid_en", count_en, 1'b0);
        weight = 12'd0;
        tick;
        reset = 1'b0;
        viol = 0;
        for (int i = 0; i < 12; i++) begin
            tick;
            viol += int'(count_en);
        end
        chk("rmid_no_more_en", viol, 0);
        chk("rmid_idle", state, S_IDLE);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
